// File: rtl/sipo_frame_receiver.sv
// Serial-in parallel-out receiver: assembles WIDTH serial bits into a word and
// hands it to a valid/ready consumer, flagging words dropped under backpressure.
module sipo_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_valid,
    input  logic                     frame_sync,
    input  logic                     p_ready,
    input  logic                     ovr_clr,
    output logic [WIDTH-1:0]         p_data,
    output logic                     p_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int            CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    RECV  = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sh_q,      sh_d;
    logic [WIDTH-1:0] p_data_q,  p_data_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] sh_shift;
    logic [WIDTH-1:0] sh_fresh;
    logic             word_done;
    logic             xfer;

    // sh_shift: register shifted with the incoming bit; sh_fresh: a new word
    // whose only content is the incoming bit (used when frame_sync realigns).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (LSB_FIRST) begin : g_lsb
                if (gi == WIDTH - 1) begin : g_entry
                    assign sh_shift[gi] = s_in;
                    assign sh_fresh[gi] = s_in;
                end else begin : g_body
                    assign sh_shift[gi] = sh_q[gi+1];
                    assign sh_fresh[gi] = 1'b0;
                end
            end else begin : g_msb
                if (gi == 0) begin : g_entry
                    assign sh_shift[gi] = s_in;
                    assign sh_fresh[gi] = s_in;
                end else begin : g_body
                    assign sh_shift[gi] = sh_q[gi-1];
                    assign sh_fresh[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign xfer      = p_valid_q & p_ready;
    assign word_done = s_valid & ~frame_sync & (bit_cnt_q == LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        if (frame_sync) begin
            if (s_valid) begin
                sh_d      = sh_fresh;
                bit_cnt_d = CW'(1);
                state_d   = RECV;
            end else begin
                sh_d      = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        end else if (s_valid) begin
            sh_d = sh_shift;
            if (word_done) begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                state_d   = RECV;
            end
        end
    end

    // A finished word is accepted if the output slot is empty or being drained
    // this same cycle; otherwise it is dropped and overrun latches.
    always_comb begin
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;
        if (word_done && (!p_valid_q || p_ready)) begin
            p_data_d  = sh_shift;
            p_valid_d = 1'b1;
        end else if (xfer) begin
            p_valid_d = 1'b0;
        end
        overrun_d = (word_done & p_valid_q & ~p_ready) | (overrun_q & ~ovr_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign busy    = (state_q == RECV);
    assign bit_cnt = bit_cnt_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench: one LSB-first and one MSB-first receiver share the same
// stimulus; a vector table plus a gapped-bit sequence check both.
module tb_sipo_frame_receiver;

    logic       clk = 1'b0;
    logic       rst, s_in, s_valid, frame_sync, p_ready, ovr_clr;
    logic [3:0] pd_l, pd_m;
    logic       pv_l, pv_m, busy_l, busy_m, ovr_l, ovr_m;
    logic [1:0] cnt_l, cnt_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_frame_receiver #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid),
        .frame_sync(frame_sync), .p_ready(p_ready), .ovr_clr(ovr_clr),
        .p_data(pd_l), .p_valid(pv_l), .busy(busy_l), .bit_cnt(cnt_l),
        .overrun(ovr_l)
    );

    sipo_frame_receiver #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid),
        .frame_sync(frame_sync), .p_ready(p_ready), .ovr_clr(ovr_clr),
        .p_data(pd_m), .p_valid(pv_m), .busy(busy_m), .bit_cnt(cnt_m),
        .overrun(ovr_m)
    );

    // in = {rst, s_valid, s_in, frame_sync, p_ready, ovr_clr}
    // st = {p_valid, busy, bit_cnt[1:0], overrun}, expected after the edge
    typedef struct {
        logic [5:0] in;
        logic [3:0] pdl;
        logic [3:0] pdm;
        logic [4:0] st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [5:0] in, input logic [3:0] pdl,
                       input logic [3:0] pdm, input logic [4:0] st);
        vec_t v;
        v.in = in; v.pdl = pdl; v.pdm = pdm; v.st = st;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {rst, s_valid, s_in, frame_sync, p_ready, ovr_clr} = in;
    endtask

    task automatic check_all(input string tag, input logic [3:0] pdl,
                             input logic [3:0] pdm, input logic [4:0] st);
        check({tag, " p_data_lsb"}, {12'd0, pd_l}, {12'd0, pdl});
        check({tag, " p_data_msb"}, {12'd0, pd_m}, {12'd0, pdm});
        check({tag, " p_valid"},    {15'd0, pv_l}, {15'd0, st[4]});
        check({tag, " p_valid_m"},  {15'd0, pv_m}, {15'd0, st[4]});
        check({tag, " busy"},       {15'd0, busy_l}, {15'd0, st[3]});
        check({tag, " busy_m"},     {15'd0, busy_m}, {15'd0, st[3]});
        check({tag, " bit_cnt"},    {14'd0, cnt_l}, {14'd0, st[2:1]});
        check({tag, " bit_cnt_m"},  {14'd0, cnt_m}, {14'd0, st[2:1]});
        check({tag, " overrun"},    {15'd0, ovr_l}, {15'd0, st[0]});
        check({tag, " overrun_m"},  {15'd0, ovr_m}, {15'd0, st[0]});
    endtask

    initial begin
        logic [3:0] gap_bits;
        logic [1:0] gap_cnt;

        drive(6'b000000);

        // reset, then word 1,1,0,1 with p_ready=1
        add(6'b100000, 4'h0, 4'h0, 5'b0_0_00_0);
        add(6'b011010, 4'h0, 4'h0, 5'b0_1_01_0);
        add(6'b011010, 4'h0, 4'h0, 5'b0_1_10_0);
        add(6'b010010, 4'h0, 4'h0, 5'b0_1_11_0);
        add(6'b011010, 4'hB, 4'hD, 5'b1_0_00_0);
        add(6'b000010, 4'hB, 4'hD, 5'b0_0_00_0);
        // backpressure: B held, 5 dropped, overrun cleared, then B drains
        add(6'b100000, 4'h0, 4'h0, 5'b0_0_00_0);
        add(6'b011000, 4'h0, 4'h0, 5'b0_1_01_0);
        add(6'b011000, 4'h0, 4'h0, 5'b0_1_10_0);
        add(6'b010000, 4'h0, 4'h0, 5'b0_1_11_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_0_00_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_01_0);
        add(6'b010000, 4'hB, 4'hD, 5'b1_1_10_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_11_0);
        add(6'b010000, 4'hB, 4'hD, 5'b1_0_00_1);
        add(6'b000001, 4'hB, 4'hD, 5'b1_0_00_0);
        add(6'b000010, 4'hB, 4'hD, 5'b0_0_00_0);
        // back-to-back: B pending, 5 completes on the draining cycle
        add(6'b011000, 4'hB, 4'hD, 5'b0_1_01_0);
        add(6'b011000, 4'hB, 4'hD, 5'b0_1_10_0);
        add(6'b010000, 4'hB, 4'hD, 5'b0_1_11_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_0_00_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_01_0);
        add(6'b010000, 4'hB, 4'hD, 5'b1_1_10_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_11_0);
        add(6'b010010, 4'h5, 4'hA, 5'b1_0_00_0);
        add(6'b000000, 4'h5, 4'hA, 5'b1_0_00_0);
        // overrun set coincides with ovr_clr: set wins
        add(6'b011000, 4'h5, 4'hA, 5'b1_1_01_0);
        add(6'b011000, 4'h5, 4'hA, 5'b1_1_10_0);
        add(6'b010000, 4'h5, 4'hA, 5'b1_1_11_0);
        add(6'b011001, 4'h5, 4'hA, 5'b1_0_00_1);
        add(6'b000011, 4'h5, 4'hA, 5'b0_0_00_0);
        add(6'b000010, 4'h5, 4'hA, 5'b0_0_00_0);
        // frame_sync with s_valid after two bits, then 1,1,1
        add(6'b011010, 4'h5, 4'hA, 5'b0_1_01_0);
        add(6'b011010, 4'h5, 4'hA, 5'b0_1_10_0);
        add(6'b010110, 4'h5, 4'hA, 5'b0_1_01_0);
        add(6'b011010, 4'h5, 4'hA, 5'b0_1_10_0);
        add(6'b011010, 4'h5, 4'hA, 5'b0_1_11_0);
        add(6'b011010, 4'hE, 4'h7, 5'b1_0_00_0);
        add(6'b000010, 4'hE, 4'h7, 5'b0_0_00_0);
        // frame_sync alone drops a partial word
        add(6'b011010, 4'hE, 4'h7, 5'b0_1_01_0);
        add(6'b000110, 4'hE, 4'h7, 5'b0_0_00_0);
        // reset mid-word with a pending word, then 0,1,0,1
        add(6'b011000, 4'hE, 4'h7, 5'b0_1_01_0);
        add(6'b011000, 4'hE, 4'h7, 5'b0_1_10_0);
        add(6'b010000, 4'hE, 4'h7, 5'b0_1_11_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_0_00_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_01_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_10_0);
        add(6'b011000, 4'hB, 4'hD, 5'b1_1_11_0);
        add(6'b111000, 4'h0, 4'h0, 5'b0_0_00_0);
        add(6'b010010, 4'h0, 4'h0, 5'b0_1_01_0);
        add(6'b011010, 4'h0, 4'h0, 5'b0_1_10_0);
        add(6'b010010, 4'h0, 4'h0, 5'b0_1_11_0);
        add(6'b011010, 4'hA, 4'h5, 5'b1_0_00_0);
        add(6'b000010, 4'hA, 4'h5, 5'b0_0_00_0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vq[i].pdl, vq[i].pdm, vq[i].st);
            $display("vec %0d in=%b p_data=%h/%h p_valid=%b busy=%b bit_cnt=%0d overrun=%b",
                     i, vq[i].in, pd_l, pd_m, pv_l, busy_l, cnt_l, ovr_l);
        end

        // bits 1,1,0,1 separated by 3-cycle s_valid gaps
        gap_bits = 4'b1011;
        for (int b = 0; b < 4; b++) begin
            gap_cnt = 2'(b + 1);
            drive({2'b01, gap_bits[b], 3'b010});
            @(posedge clk);
            #1;
            check($sformatf("gap bit%0d bit_cnt", b), {14'd0, cnt_l}, {14'd0, gap_cnt});
            check($sformatf("gap bit%0d bit_cnt_m", b), {14'd0, cnt_m}, {14'd0, gap_cnt});
            if (b == 3) begin
                check("gap word p_data_lsb", {12'd0, pd_l}, 16'h000B);
                check("gap word p_data_msb", {12'd0, pd_m}, 16'h000D);
                check("gap word p_valid", {15'd0, pv_l}, 16'd1);
            end else begin
                for (int g = 0; g < 3; g++) begin
                    drive(6'b000010);
                    @(posedge clk);
                    #1;
                    check($sformatf("gap bit%0d hold%0d bit_cnt", b, g), {14'd0, cnt_l}, {14'd0, gap_cnt});
                    check($sformatf("gap bit%0d hold%0d busy", b, g), {15'd0, busy_l}, 16'd1);
                end
            end
            $display("gap bit %0d s_in=%b bit_cnt=%0d p_data=%h/%h p_valid=%b",
                     b, gap_bits[b], cnt_l, pd_l, pd_m, pv_l);
        end
        drive(6'b000010);
        @(posedge clk);
        #1;
        check("gap drain p_valid", {15'd0, pv_l}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_frame_receiver.md
SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of serial bits per parallel word (legal range 2..16).
REQ-002 Parameter LSB_FIRST, default 1, SHALL select bit order: 1 means the first received bit lands in p_data[0]; 0 means it lands in p_data[WIDTH-1].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 s_in  input  1  SHALL carry the serial data bit (the serial output of the upstream parallel-to-serial stage).
REQ-006 s_valid  input  1  SHALL qualify s_in; a bit is consumed only on a cycle with s_valid=1.
REQ-007 frame_sync  input  1  SHALL discard any partial word and realign to a word boundary.
REQ-008 p_ready  input  1  SHALL indicate the consumer accepts p_data this cycle.
REQ-009 p_data  output  WIDTH  SHALL carry the assembled parallel word.
REQ-010 p_valid  output  1  SHALL indicate p_data holds an unconsumed word.
REQ-011 busy  output  1  SHALL be 1 while a partial word is held (state RECV).
REQ-012 bit_cnt  output  clog2(WIDTH)  SHALL report the number of bits held in the partial word.
REQ-013 overrun  input/output: output  1  SHALL be a sticky flag for a dropped word.
REQ-014 ovr_clr  input  1  SHALL clear overrun.

Function
REQ-015 The state machine SHALL have two states, IDLE (bit_cnt=0) and RECV (bit_cnt in 1..WIDTH-1); busy=1 exactly in RECV.
REQ-016 On s_valid=1, the shift register SHALL update {s_in, sh[WIDTH-1:1]} when LSB_FIRST=1, or {sh[WIDTH-2:0], s_in} when LSB_FIRST=0.
REQ-017 On s_valid=1, bit_cnt SHALL increment; IDLE->RECV on the first bit.
REQ-018 On s_valid=1 with bit_cnt=WIDTH-1, a word SHALL complete: the word is the shifted value including the current bit, bit_cnt wraps to 0, and the state returns to IDLE.
REQ-019 With s_valid=0, sh, bit_cnt and state SHALL hold; gaps of any length SHALL be tolerated.
REQ-020 frame_sync=1 SHALL force bit_cnt to 0 and discard the partial word.
REQ-021 frame_sync=1 with s_valid=1 in the same cycle SHALL treat s_in as bit 0 of a new word (bit_cnt becomes 1); no completion occurs that cycle.
REQ-022 A completed word SHALL be loaded into p_data, with p_valid=1 from the next cycle, when p_valid=0, or when p_valid=1 and p_ready=1 in the same cycle (back-to-back, no bubble).
REQ-023 Latency SHALL be one edge: p_valid is visible immediately after the edge that samples the last bit.
REQ-024 A word transfer SHALL occur on p_valid=1 and p_ready=1; p_valid SHALL fall after the transfer unless a word completes in that same cycle.
REQ-025 While p_valid=1 and p_ready=0, p_data SHALL be held stable.
REQ-026 A word that completes while p_valid=1 and p_ready=0 SHALL be dropped: p_data is unchanged and overrun is set to 1.
REQ-027 overrun SHALL remain 1 until ovr_clr=1; if a new overrun coincides with ovr_clr, set SHALL win.
REQ-028 p_ready SHALL be ignored while p_valid=0.

Reset
REQ-029 rst=1 SHALL set p_data=0, p_valid=0, overrun=0, bit_cnt=0, sh=0 and state IDLE, overriding all other inputs in that cycle.
REQ-030 rst asserted mid-word SHALL discard the partial word and any pending p_data; the first s_valid after reset is bit 0.

Verification
REQ-031 WIDTH=4, LSB_FIRST=1, p_ready=1, bits 1,1,0,1 on consecutive cycles -> p_data=4'hB with p_valid=1 for one cycle after the 4th edge; busy=1 during bits 2-4.
REQ-032 LSB_FIRST=0, same bits -> p_data=4'hD; same bits with s_valid gaps of 3 cycles -> identical result, bit_cnt stepping 1,2,3,0.
REQ-033 p_ready=0, send words 4'hB then 4'h5 -> p_data stays 4'hB, overrun=1; ovr_clr pulse -> overrun=0; p_ready=1 -> 4'hB transfers, p_valid=0.
REQ-034 p_valid=1 with 4'hB and p_ready=1 on the cycle 4'h5 completes -> 4'hB transfers, p_data=4'h5 with p_valid=1 next cycle, overrun=0.
REQ-035 After 2 bits, frame_sync with s_valid=1, s_in=0, then bits 1,1,1 -> bit_cnt=1 after sync and p_data=4'hE.
REQ-036 rst after 3 bits of a word and with p_valid=1 -> all outputs are 0 next cycle; the next 4 bits 0,1,0,1 -> p_data=4'hA.
